// File: rtl/panel_seq.sv
// Front-panel sequencer: turns debounced button pulses into core run/step/reset
// control, owns the memory port while the core is parked, and drives the display register.
module panel_seq #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int CNT_W      = 4,
  parameter int SETTLE_CYC = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              btn_load_i,
  input  logic              btn_look_i,
  input  logic              btn_step_i,
  input  logic              btn_run_i,
  input  logic              btn_enter_i,
  input  logic              btn_stop_i,
  output logic              btn_load_o,
  output logic              btn_look_o,
  output logic              btn_step_o,
  output logic              btn_run_o,
  output logic              btn_enter_o,
  output logic              btn_stop_o,
  output logic              led_ready_o,
  output logic              led_inwait_o,
  output logic              led_brk_o,
  input  logic [ADDR_W-1:0] sw_addr_i,
  input  logic [DATA_W-1:0] sw_data_i,
  output logic [DATA_W-1:0] sw_data_o,
  input  logic [CNT_W-1:0]  step_cnt_i,
  input  logic              brk_en_i,
  input  logic [ADDR_W-1:0] brk_addr_i,
  input  logic              stdin_rdy_i,
  input  logic              inwait_i,
  input  logic              cpu_halt_i,
  input  logic              cpu_done_i,
  input  logic              instr_val_i,
  input  logic [DATA_W-1:0] instr_data_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              core_rst_no,
  output logic [1:0]        cpu_exec_o,
  output logic              pc_wen_o,
  output logic              mem_sel_o,
  output logic              mem_val_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_rdy_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stdout_flush_o
);

  localparam int SC_W = $clog2(SETTLE_CYC + 1);
  localparam logic [SC_W-1:0]  SC_LOAD = SC_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_READY, S_STEP, S_RUN, S_DRAIN, S_SETTLE, S_INWAIT, S_HALT
  } state_t;

  state_t             r_state;
  state_t             r_target;
  logic [CNT_W-1:0]   r_remaining;
  logic [SC_W-1:0]    r_settle;
  logic [ADDR_W-1:0]  r_pc_hold;
  logic               r_brk;
  logic [DATA_W-1:0]  r_disp;
  logic               r_pend;

  logic               w_service;
  logic               w_load;
  logic               w_look;
  logic               w_settle_req;
  logic               w_svc_acc;
  logic               w_hit;
  logic               w_running;
  logic [CNT_W-1:0]   w_cnt_eff;

  assign w_service    = (r_state == S_READY) || (r_state == S_INWAIT) || (r_state == S_HALT);
  assign w_load       = w_service & btn_load_i;
  assign w_look       = w_service & btn_look_i & ~btn_load_i;
  assign w_settle_req = (r_state == S_SETTLE) && (r_settle == '0);
  assign w_svc_acc    = (w_load | w_look) & mem_rdy_i;
  assign w_hit        = brk_en_i & instr_val_i & (pc_i == brk_addr_i);
  assign w_running    = (r_state == S_STEP) || (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_cnt_eff    = (step_cnt_i == '0) ? CNT_ONE : step_cnt_i;

  // Memory port: button service in parked states, settle read of the held PC otherwise.
  assign mem_val_o   = w_load | w_look | w_settle_req;
  assign mem_wen_o   = w_load;
  assign mem_addr_o  = w_settle_req ? r_pc_hold : sw_addr_i;
  assign mem_wdata_o = sw_data_i;
  assign pc_wen_o    = w_load | w_look;
  assign sw_data_o   = r_disp;
  assign led_brk_o   = r_brk;

  always_comb begin
    btn_load_o     = 1'b0;
    btn_look_o     = 1'b0;
    btn_step_o     = 1'b0;
    btn_run_o      = 1'b0;
    btn_enter_o    = 1'b0;
    btn_stop_o     = 1'b0;
    led_ready_o    = 1'b0;
    led_inwait_o   = 1'b0;
    core_rst_no    = 1'b0;
    cpu_exec_o     = 2'd0;
    mem_sel_o      = 1'b0;
    stdout_flush_o = 1'b1;
    case (r_state)
      S_READY: begin
        btn_load_o  = 1'b1;
        btn_look_o  = 1'b1;
        btn_step_o  = 1'b1;
        btn_run_o   = 1'b1;
        btn_enter_o = stdin_rdy_i;
        led_ready_o = 1'b1;
        mem_sel_o   = 1'b1;
      end
      S_STEP: begin
        core_rst_no = 1'b1;
        cpu_exec_o  = (r_remaining != '0) ? 2'd2 : 2'd0;
      end
      S_RUN: begin
        core_rst_no    = 1'b1;
        cpu_exec_o     = 2'd1;
        btn_stop_o     = 1'b1;
        stdout_flush_o = 1'b0;
      end
      S_DRAIN: core_rst_no = 1'b1;
      S_SETTLE: begin
        // The core keeps running only for the first settle cycle, then is held in reset.
        core_rst_no = (r_settle == SC_LOAD);
        mem_sel_o   = 1'b1;
      end
      S_INWAIT: begin
        btn_load_o   = 1'b1;
        btn_look_o   = 1'b1;
        btn_enter_o  = 1'b1;
        led_inwait_o = 1'b1;
        mem_sel_o    = 1'b1;
      end
      S_HALT: begin
        btn_load_o  = 1'b1;
        btn_look_o  = 1'b1;
        btn_enter_o = stdin_rdy_i;
        led_ready_o = 1'b1;
        mem_sel_o   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_READY;
      r_target    <= S_READY;
      r_remaining <= '0;
      r_settle    <= '0;
      r_pc_hold   <= '0;
      r_brk       <= 1'b0;
      r_disp      <= '0;
      r_pend      <= 1'b0;
    end else begin
      // A read result is only valid the cycle after acceptance.
      r_pend <= (w_look | w_settle_req) & mem_rdy_i;
      if (instr_val_i)
        r_disp <= instr_data_i;
      else if (w_load && mem_rdy_i)
        r_disp <= sw_data_i;
      else if (r_pend)
        r_disp <= mem_rdata_i;

      if (w_svc_acc)
        r_brk <= 1'b0;
      else if (w_running && w_hit)
        r_brk <= 1'b1;

      case (r_state)
        S_READY: begin
          if (btn_run_i) begin
            r_state <= S_RUN;
            r_brk   <= 1'b0;
          end else if (btn_step_i) begin
            r_state     <= S_STEP;
            r_remaining <= w_cnt_eff;
            r_brk       <= 1'b0;
          end
        end
        S_STEP: begin
          if (instr_val_i && r_remaining != '0)
            r_remaining <= r_remaining - CNT_ONE;
          if (inwait_i) begin
            r_state  <= S_SETTLE;
            r_target <= S_INWAIT;
            r_settle <= SC_LOAD;
          end else if (cpu_halt_i) begin
            r_state  <= S_SETTLE;
            r_target <= S_HALT;
            r_settle <= SC_LOAD;
          end else if (w_hit || (instr_val_i && r_remaining == CNT_ONE)) begin
            r_state <= S_DRAIN;
          end
        end
        S_RUN: begin
          if (inwait_i) begin
            r_state  <= S_SETTLE;
            r_target <= S_INWAIT;
            r_settle <= SC_LOAD;
          end else if (cpu_halt_i) begin
            r_state  <= S_SETTLE;
            r_target <= S_HALT;
            r_settle <= SC_LOAD;
          end else if (w_hit || btn_stop_i) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (inwait_i) begin
            r_state  <= S_SETTLE;
            r_target <= S_INWAIT;
            r_settle <= SC_LOAD;
          end else if (cpu_halt_i) begin
            r_state  <= S_SETTLE;
            r_target <= S_HALT;
            r_settle <= SC_LOAD;
          end else if (cpu_done_i) begin
            r_state <= S_READY;
          end
        end
        S_SETTLE: begin
          // Latch the PC before core reset scrambles it.
          if (r_settle == SC_LOAD)
            r_pc_hold <= pc_i;
          if (r_settle != '0)
            r_settle <= r_settle - SC_W'(1);
          else if (mem_rdy_i)
            r_state <= r_target;
        end
        S_INWAIT: begin
          if (btn_enter_i)
            r_state <= S_READY;
        end
        S_HALT: begin
          if (w_svc_acc)
            r_state <= S_READY;
        end
        default: r_state <= S_READY;
      endcase
    end
  end

endmodule

// File: doc/panel_seq.md
# panel_seq

Parametrised front-panel sequencer: the successor to the fixed TOY panel FSM. It turns debounced panel button pulses into core run/step/reset control, owns the main-memory read/write port whenever the core is parked, and maintains the data display register. New capabilities over the previous generation:

- configurable address and data widths;
- multi-instruction step (N retirements per STEP press);
- hardware PC breakpoint;
- configurable settle length before a parked memory read.

## Interface

Parameters:
- ADDR_W, 8, address/PC width
- DATA_W, 16, data/instruction width
- CNT_W, 4, width of the step-count input
- SETTLE_CYC, 3, cycles spent in SETTLE before the parked read (must be >= 1)

Ports (clock and reset first):
- clk_i  in  1  sole clock
- rst_i  in  1  synchronous, active-high reset
- btn_load_i / btn_look_i / btn_step_i / btn_run_i / btn_enter_i / btn_stop_i  in  1 each  single-cycle debounced press pulses
- btn_load_o / btn_look_o / btn_step_o / btn_run_o / btn_enter_o / btn_stop_o  out  1 each  button-enable lamps
- led_ready_o, led_inwait_o, led_brk_o  out  1 each  status LEDs
- sw_addr_i  in  ADDR_W  address switches
- sw_data_i  in  DATA_W  data switches
- sw_data_o  out  DATA_W  data display register
- step_cnt_i  in  CNT_W  instructions per STEP press; 0 is treated as 1
- brk_en_i  in  1  breakpoint enable
- brk_addr_i  in  ADDR_W  breakpoint PC
- stdin_rdy_i  in  1  stdin FIFO can accept a word
- inwait_i  in  1  core stalled on empty stdin
- cpu_halt_i  in  1  core executed halt
- cpu_done_i  in  1  core quiescent, no instruction in flight
- instr_val_i  in  1  instruction retired this cycle
- instr_data_i  in  DATA_W  retired instruction
- pc_i  in  ADDR_W  core PC after the current retirement
- core_rst_no  out  1  core soft reset, active-low
- cpu_exec_o  out  2  0 idle, 1 run, 2 step
- pc_wen_o  out  1  load sw_addr_i into core PC
- mem_sel_o  out  1  panel owns the memory port (external mux)
- mem_val_o, mem_wen_o  out  1 each  panel request and write enable
- mem_addr_o  out  ADDR_W  panel request address
- mem_wdata_o  out  DATA_W  panel write data
- mem_rdy_i  in  1  request accepted when mem_val_o && mem_rdy_i
- mem_rdata_i  in  DATA_W  read data, valid the cycle after acceptance
- stdout_flush_o  out  1  flush stdout

## Operation

States: READY, STEP, RUN, DRAIN, SETTLE, INWAIT, HALT.

Default outputs (apply in every state unless overridden below): all enables and LEDs 0, core_rst_no 0, cpu_exec_o 0, stdout_flush_o 1.

- **READY**
  - Outputs: load/look/step/run enables 1; btn_enter_o = stdin_rdy_i; led_ready_o 1; mem_sel_o 1.
  - Transitions: run → RUN (brk flag cleared); else step → STEP (remaining = max(step_cnt_i, 1), brk flag cleared).
- **STEP**
  - Outputs: core_rst_no 1; cpu_exec_o 2 until remaining reaches 0.
  - Each instr_val_i decrements remaining.
  - Exit priority: inwait_i → SETTLE(INWAIT); cpu_halt_i → SETTLE(HALT); breakpoint hit or last retirement → DRAIN.
- **RUN**
  - Outputs: core_rst_no 1; cpu_exec_o 1; btn_stop_o 1; stdout_flush_o 0.
  - Exit priority: inwait_i > cpu_halt_i > breakpoint > btn_stop_i. Breakpoint and stop go to DRAIN.
- **Breakpoint hit:** brk_en_i && instr_val_i && pc_i == brk_addr_i. Sets the brk flag (drives led_brk_o). The flag clears on RUN/STEP entry, load, look, or reset.
- **DRAIN**
  - Outputs: core_rst_no 1; cpu_exec_o 0.
  - Transitions: cpu_done_i → READY; inwait_i/cpu_halt_i → SETTLE as in RUN.
- **SETTLE(target)**
  - Counter loads SETTLE_CYC on entry and decrements to 0.
  - core_rst_no is 1 only in the first SETTLE cycle, then 0.
  - mem_sel_o 1. At counter 0: mem_val_o 1, mem_wen_o 0, mem_addr_o = pc_i (held across core reset).
  - On acceptance → target state; sw_data_o ← mem_rdata_i on the following cycle.
- **INWAIT**
  - Outputs: load/look/enter enables 1; led_inwait_o 1; mem_sel_o 1.
  - Transition: btn_enter_i → READY.
- **HALT**
  - Outputs: load/look enables 1; btn_enter_o = stdin_rdy_i; led_ready_o 1; mem_sel_o 1.
  - Transition: load/look press → READY (the press is also serviced).
- **Load/look** (serviced in READY, INWAIT, HALT)
  - Request: mem_val_o = load|look; mem_wen_o = load; mem_addr_o = sw_addr_i; mem_wdata_o = sw_data_i; pc_wen_o = load|look.
  - Load wins if both are pressed in the same cycle.
  - Acceptance is required. If mem_rdy_i is 0, the press is dropped: no display update, no state change.
- **Display update priority:** reset > instr_val_i (instr_data_i) > accepted load (sw_data_i) > pending look/settle read (mem_rdata_i).

## Timing

- Reset, sampled on clk_i: next cycle READY; sw_data_o 0; brk flag 0; remaining 0; no pending read.
  - Resulting outputs: led_ready_o 1, core_rst_no 0, cpu_exec_o 0, mem_val_o 0.
  - Reset mid-run or mid-SETTLE discards any pending read.
- Every state transition takes one cycle from the triggering input.
- Look latency: press cycle accepted → sw_data_o updated 2 cycles after the press edge.
- SETTLE: SETTLE_CYC + 1 cycles minimum (plus memory stall cycles) before the target state.
- A STEP with count N leaves cpu_exec_o = 2 for exactly the cycles up to and including the Nth instr_val_i.
- Widths are exact: no arithmetic beyond the CNT_W decrement, which saturates at 0.

## Test plan

- Reset, then press look with sw_addr_i = 0x10, memory[0x10] = 0xBEEF → mem_val_o 1 in the press cycle; sw_data_o = 0xBEEF two edges later; state stays READY.
- step_cnt_i = 3, press step, core retires at cycles 2/5/7 → cpu_exec_o = 2 through cycle 7; DRAIN; READY after cpu_done_i; sw_data_o = third instr_data_i.
- RUN with brk_en_i = 1, brk_addr_i = 0x22; retire with pc_i = 0x22 → DRAIN; led_brk_o 1; READY; a subsequent run press clears led_brk_o.
- RUN, inwait_i rises, SETTLE_CYC = 3, mem_rdy_i low for 2 cycles → core_rst_no 1 for one cycle then 0; read of pc_i issued; INWAIT entered on acceptance; enter → READY.
- cpu_halt_i in RUN and btn_stop_i in the same cycle → SETTLE(HALT) wins; in HALT, load with 0x1234 at 0x05 → write issued, pc_wen_o 1, sw_data_o = 0x1234, READY.
- rst_i asserted mid-SETTLE → next cycle READY; sw_data_o = 0; no mem_val_o.
